vga_timing_gen: RTL and testbench
=================================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters (name, default, meaning): H_ACTIVE 640 visible pixels; H_FRONT 16 h front porch; H_SYNC 96 h sync width; H_BACK 48 h back porch; V_ACTIVE 480 visible lines; V_FRONT 10; V_SYNC 2; V_BACK 33; HS_POL 0 h_sync active level; VS_POL 0 v_sync active level; CLK_DIV 2 clk cycles per pixel; CW 10 coordinate width.
REQ-002 SHALL have ports: clk in 1 clock; rst in 1 reset, synchronous, active-high; en in 1 timing advance enable; h_sync out 1; v_sync out 1; blank_n out 1 high in visible region; sync_n out 1 composite sync, tied 0; posx out CW pixel column; posy out CW pixel line; pix_tick out 1 pixel strobe; frame_start out 1 frame pulse; line_start out 1 line pulse.
REQ-003 SHALL use one clock domain, clk; reset is synchronous and active-high on rst.

Function
REQ-004 SHALL define H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL likewise; defaults give 800 x 525.
REQ-005 SHALL run a prescaler 0..CLK_DIV-1 while en=1; pix_tick=1 for exactly one clk when prescaler=CLK_DIV-1 and en=1; CLK_DIV=1 gives pix_tick=en.
REQ-006 SHALL advance hcnt by 1 on each pix_tick, wrapping H_TOTAL-1 -> 0; vcnt SHALL advance only on that hcnt wrap, wrapping V_TOTAL-1 -> 0.
REQ-007 SHALL drive posx=hcnt, posy=vcnt (raw, not clamped); consumers qualify with blank_n.
REQ-008 SHALL order each line: active [0,H_ACTIVE-1], front porch, sync [H_ACTIVE+H_FRONT, H_ACTIVE+H_FRONT+H_SYNC-1], back porch; vertical identical using V_ parameters.
REQ-009 SHALL drive h_sync=HS_POL inside the h sync window, else ~HS_POL; v_sync likewise with VS_POL.
REQ-010 SHALL drive blank_n=1 iff hcnt<H_ACTIVE and vcnt<V_ACTIVE.
REQ-011 SHALL register h_sync, v_sync, blank_n so that they change on the same clk edge as the counters and match the current posx/posy (zero pixel skew, glitch-free).
REQ-012 SHALL pulse line_start for one clk in the cycle after hcnt wraps to 0; frame_start SHALL pulse one clk in the cycle after (hcnt,vcnt) wraps to (0,0); both coincide at frame start.
REQ-013 SHALL freeze prescaler, counters and all outputs while en=0; pulses SHALL NOT repeat while frozen.
REQ-014 SHALL give rst priority over en on any cycle, including mid-line and mid-frame.
REQ-015 SHALL require CW to hold max(H_TOTAL,V_TOTAL)-1 and CLK_DIV>=1; other parameter values are unsupported.

Reset
REQ-016 SHALL set on rst: prescaler=0, hcnt=0, vcnt=0, posx=0, posy=0, pix_tick=0, frame_start=0, line_start=0, h_sync=~HS_POL, v_sync=~VS_POL, sync_n=0.
REQ-017 SHALL set blank_n=1 on rst (pixel (0,0) visible); frame_start SHALL NOT pulse on reset release.

Configuration
REQ-018 SHALL support macro VGA_TIMING_LOOKAHEAD_EN: when defined, h_sync, v_sync, blank_n are re-registered on pix_tick and lag posx/posy by exactly one pixel, so a 1-cycle-latency framebuffer read addressed by posx/posy aligns with blank_n; reset values then h_sync=~HS_POL, v_sync=~VS_POL, blank_n=0.
REQ-019 SHALL, when VGA_TIMING_LOOKAHEAD_EN is undefined, behave per REQ-011 (zero skew); ports identical in both builds.

Verification
REQ-020 Defaults, en=1 after rst: pix_tick every 2nd clk; posx=639 blank_n=1 -> next tick posx=640 blank_n=0.
REQ-021 Horizontal: h_sync=0 for posx 656..751, 1 at 752; posx 799 -> 0 with posy+1 and line_start one clk; HS_POL=1 build inverts h_sync.
REQ-022 Vertical/frame: v_sync=0 for posy 490..491; wrap at (799,524) -> (0,0); frame_start exactly once per 840000 clk.
REQ-023 en=0 for 10 clk at posx=100: posx, posy, prescaler, sync outputs hold; pix_tick=0; resume at posx=101 on next tick.
REQ-024 rst at posy=300, posx=400: next clk all outputs at REQ-016/017 values; CLK_DIV=1 build gives posx +1 every clk.
REQ-025 VGA_TIMING_LOOKAHEAD_EN: after rst posx=0, blank_n=0; after first pix_tick posx=1, blank_n=1; h_sync falls while posx=657.

Source files
------------

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel prescaler, h/v counters, registered sync/blank and line/frame pulses.
// Define VGA_TIMING_LOOKAHEAD_EN to delay h_sync/v_sync/blank_n by one pixel for 1-cycle framebuffer reads.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FRONT  = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BACK   = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FRONT  = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BACK   = 33,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CW       = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          h_sync,
  output logic          v_sync,
  output logic          blank_n,
  output logic          sync_n,
  output logic [CW-1:0] posx,
  output logic [CW-1:0] posy,
  output logic          pix_tick,
  output logic          frame_start,
  output logic          line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [PW-1:0] P_LAST  = PW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST  = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST  = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT   = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT   = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_BEG  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_BEG  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [PW-1:0] presc;
  logic [CW-1:0] hcnt, vcnt, h_next, v_next;
  logic          tick, h_wrap, v_wrap;
  logic          hs_cur, vs_cur, bl_cur;
  logic          hs_nxt, vs_nxt, bl_nxt;

  assign tick     = en & ~rst & (presc == P_LAST);
  assign pix_tick = tick;
  assign posx     = hcnt;
  assign posy     = vcnt;
  assign sync_n   = 1'b0;

  // Decode sync/blank from the next counter values so the registered
  // outputs land on the same edge as the counters they describe.
  always_comb begin
    h_next = hcnt;
    v_next = vcnt;
    h_wrap = (hcnt == H_LAST);
    v_wrap = (vcnt == V_LAST);
    if (tick) begin
      if (h_wrap) begin
        h_next = '0;
        v_next = v_wrap ? '0 : vcnt + 1'b1;
      end else begin
        h_next = hcnt + 1'b1;
      end
    end
    hs_nxt = (h_next >= HS_BEG && h_next <= HS_LAST) ? HS_POL : ~HS_POL;
    vs_nxt = (v_next >= VS_BEG && v_next <= VS_LAST) ? VS_POL : ~VS_POL;
    bl_nxt = (h_next < H_ACT) && (v_next < V_ACT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc       <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      hs_cur      <= ~HS_POL;
      vs_cur      <= ~VS_POL;
      bl_cur      <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      if (en) begin
        presc <= (presc == P_LAST) ? '0 : presc + 1'b1;
      end
      hcnt        <= h_next;
      vcnt        <= v_next;
      hs_cur      <= hs_nxt;
      vs_cur      <= vs_nxt;
      bl_cur      <= bl_nxt;
      line_start  <= tick & h_wrap;
      frame_start <= tick & h_wrap & v_wrap;
    end
  end

`ifdef VGA_TIMING_LOOKAHEAD_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      h_sync  <= ~HS_POL;
      v_sync  <= ~VS_POL;
      blank_n <= 1'b0;
    end else if (tick) begin
      h_sync  <= hs_cur;
      v_sync  <= vs_cur;
      blank_n <= bl_cur;
    end
  end
`else
  assign h_sync  = hs_cur;
  assign v_sync  = vs_cur;
  assign blank_n = bl_cur;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a tiny-timing instance (CLK_DIV=1, HS_POL=1),
// checked every cycle against a tick-count model and pinned with hand-computed directed checks.
module tb_vga_timing_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] px[2], py[2];
  logic hs[2], vs[2], bl[2], sn[2], pt[2], fs[2], ls[2];

  vga_timing_gen u_a (
    .clk(clk), .rst(rst), .en(en), .h_sync(hs[0]), .v_sync(vs[0]), .blank_n(bl[0]),
    .sync_n(sn[0]), .posx(px[0]), .posy(py[0]), .pix_tick(pt[0]),
    .frame_start(fs[0]), .line_start(ls[0]));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(1), .CW(10)
  ) u_b (
    .clk(clk), .rst(rst), .en(en), .h_sync(hs[1]), .v_sync(vs[1]), .blank_n(bl[1]),
    .sync_n(sn[1]), .posx(px[1]), .posy(py[1]), .pix_tick(pt[1]),
    .frame_start(fs[1]), .line_start(ls[1]));

  int p_div[2] = '{2, 1};
  int p_ha[2]  = '{640, 8};
  int p_hf[2]  = '{16, 2};
  int p_hs[2]  = '{96, 3};
  int p_hb[2]  = '{48, 3};
  int p_va[2]  = '{480, 4};
  int p_vf[2]  = '{10, 1};
  int p_vs[2]  = '{2, 2};
  int p_vb[2]  = '{33, 2};
  int p_hp[2]  = '{0, 1};
  int p_vp[2]  = '{0, 0};

  int checks = 0;
  int passes = 0;

  function automatic int htot(input int k);
    return p_ha[k] + p_hf[k] + p_hs[k] + p_hb[k];
  endfunction
  function automatic int vtot(input int k);
    return p_va[k] + p_vf[k] + p_vs[k] + p_vb[k];
  endfunction

  task automatic check(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s inst%0d: got %0d expected %0d at %0t", nm, k, act, exp, $time);
  endtask

  // Model state: enabled clocks since reset (e) and pixel ticks since reset (n).
  int m_e[2], m_n[2];
  bit m_ls[2], m_fs[2];
  bit valid = 0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_e[k] = 0; m_n[k] = 0; m_ls[k] = 0; m_fs[k] = 0;
      end else begin
        if (en && (m_e[k] % p_div[k] == p_div[k] - 1)) begin
          m_ls[k] = (m_n[k] % htot(k) == htot(k) - 1);
          m_fs[k] = (m_n[k] % (htot(k) * vtot(k)) == htot(k) * vtot(k) - 1);
          m_n[k]++;
        end else begin
          m_ls[k] = 0; m_fs[k] = 0;
        end
        if (en) m_e[k]++;
      end
    end
    if (rst) valid = 1;
  end

  always @(negedge clk) begin
    if (valid) begin
      for (int k = 0; k < 2; k++) begin
        int x, y, hw, vw;
        x  = m_n[k] % htot(k);
        y  = (m_n[k] / htot(k)) % vtot(k);
        hw = (x >= p_ha[k] + p_hf[k]) && (x < p_ha[k] + p_hf[k] + p_hs[k]);
        vw = (y >= p_va[k] + p_vf[k]) && (y < p_va[k] + p_vf[k] + p_vs[k]);
        check("posx", k, px[k], x);
        check("posy", k, py[k], y);
        check("h_sync", k, hs[k], hw ? p_hp[k] : 1 - p_hp[k]);
        check("v_sync", k, vs[k], vw ? p_vp[k] : 1 - p_vp[k]);
        check("blank_n", k, bl[k], (x < p_ha[k]) && (y < p_va[k]));
        check("pix_tick", k, pt[k], en && !rst && (m_e[k] % p_div[k] == p_div[k] - 1));
        check("line_start", k, ls[k], m_ls[k]);
        check("frame_start", k, fs[k], m_fs[k]);
        check("sync_n", k, sn[k], 0);
      end
    end
  end

  task automatic wait_pos(input int k, input int x, input int y, input int budget);
    int i;
    i = 0;
    @(negedge clk);
    while (!(px[k] == x && py[k] == y) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check($sformatf("reach(%0d,%0d)", x, y), k, (px[k] == x && py[k] == y), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fcnt;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("rst_posx", 0, px[0], 0);
    check("rst_posy", 0, py[0], 0);
    check("rst_blank_n", 0, bl[0], 1);
    check("rst_h_sync", 0, hs[0], 1);
    check("rst_v_sync", 0, vs[0], 1);
    check("rst_frame_start", 0, fs[0], 0);
    check("rst_pix_tick", 0, pt[0], 0);
    check("div1_pix_tick", 1, pt[1], 1);
    @(negedge clk);
    check("div1_posx_step", 1, px[1], 1);
    check("div2_posx_hold", 0, px[0], 0);
    @(negedge clk);
    check("div2_posx_step", 0, px[0], 1);

    fcnt = 0;
    repeat (1440) begin
      @(negedge clk);
      fcnt += fs[1];
    end
    check("frames_in_1440", 1, fcnt, 10);

    wait_pos(0, 639, 1, 5000);
    check("blank_n_639", 0, bl[0], 1);
    wait_pos(0, 640, 1, 4);
    check("blank_n_640", 0, bl[0], 0);
    wait_pos(0, 655, 1, 100);
    check("h_sync_655", 0, hs[0], 1);
    wait_pos(0, 656, 1, 4);
    check("h_sync_656", 0, hs[0], 0);
    wait_pos(0, 751, 1, 400);
    check("h_sync_751", 0, hs[0], 0);
    wait_pos(0, 752, 1, 4);
    check("h_sync_752", 0, hs[0], 1);
    wait_pos(0, 0, 2, 200);
    check("line_start_wrap", 0, ls[0], 1);
    @(negedge clk);
    check("line_start_once", 0, ls[0], 0);

    wait_pos(0, 100, 2, 400);
    @(posedge clk);
    #1 en = 0;
    repeat (10) begin
      @(negedge clk);
      check("frozen_posx", 0, px[0], 100);
      check("frozen_pix_tick", 0, pt[0], 0);
    end
    @(posedge clk);
    #1 en = 1;
    wait_pos(0, 101, 2, 4);

    wait_pos(0, 400, 2, 1000);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check("mid_rst_posx", 0, px[0], 0);
    check("mid_rst_posy", 0, py[0], 0);
    check("mid_rst_blank_n", 0, bl[0], 1);
    check("mid_rst_h_sync", 0, hs[0], 1);
    check("mid_rst_frame_start", 0, fs[0], 0);

    wait_pos(1, 9, 0, 200);
    check("b_h_sync_9", 1, hs[1], 0);
    wait_pos(1, 10, 0, 4);
    check("b_h_sync_10", 1, hs[1], 1);
    wait_pos(1, 0, 4, 200);
    check("b_v_sync_4", 1, vs[1], 1);
    check("b_blank_n_y4", 1, bl[1], 0);
    wait_pos(1, 0, 5, 200);
    check("b_v_sync_5", 1, vs[1], 0);
    wait_pos(1, 15, 8, 200);
    @(negedge clk);
    check("b_wrap_posx", 1, px[1], 0);
    check("b_wrap_posy", 1, py[1], 0);
    check("b_frame_start", 1, fs[1], 1);
    check("b_line_start", 1, ls[1], 1);
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
